// File: rtl/farm_sensor_bus_tx.sv
// Drives the monitor tile's input bus: single sensor samples when idle, or a
// complete framed camera image (vsync, href lines with gaps, tail) on request.
module farm_sensor_bus_tx #(
    parameter int LINE_LEN  = 16,
    parameter int LINES     = 8,
    parameter int LINE_GAP  = 2,
    parameter int VSYNC_CYC = 2,
    parameter int TAIL_CYC  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       sens_valid,
    input  logic [1:0] sens_id,
    input  logic [7:0] sens_data,
    output logic       sens_ready,
    input  logic       frame_req,
    input  logic       pix_valid,
    input  logic [7:0] pix_data,
    output logic       pix_ready,
    output logic [7:0] bus_data,
    output logic       bus_mode_camera,
    output logic       bus_vsync,
    output logic       bus_href,
    output logic [1:0] bus_sel,
    output logic       bus_ena,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam int COL_W  = (LINE_LEN > 1) ? $clog2(LINE_LEN) : 1;
    localparam int ROW_W  = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int PH_MAX = (VSYNC_CYC > LINE_GAP)
                          ? ((VSYNC_CYC > TAIL_CYC) ? VSYNC_CYC : TAIL_CYC)
                          : ((LINE_GAP > TAIL_CYC) ? LINE_GAP : TAIL_CYC);
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(LINE_LEN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(LINES - 1);
    localparam logic [PH_W-1:0]  VS_LAST   = PH_W'(VSYNC_CYC - 1);
    localparam logic [PH_W-1:0]  GAP_LAST  = PH_W'(LINE_GAP - 1);
    localparam logic [PH_W-1:0]  TAIL_LAST = PH_W'(TAIL_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_LINE,
        S_GAP,
        S_TAIL
    } state_t;

    state_t           state_reg;
    logic [COL_W-1:0] col_reg;
    logic [ROW_W-1:0] row_reg;
    logic [PH_W-1:0]  phase_reg;
    logic             pending_reg;
    logic [7:0]       bus_data_reg;
    logic             bus_mode_camera_reg;
    logic             bus_vsync_reg;
    logic             bus_href_reg;
    logic [1:0]       bus_sel_reg;
    logic             bus_ena_reg;
    logic             busy_reg;
    logic             frame_done_reg;
    logic             underrun_reg;

    logic       frame_start;
    logic [7:0] pix_byte;

    assign frame_start = pending_reg || frame_req;
    assign pix_byte    = pix_valid ? pix_data : 8'h00;

    // A frame request always wins over a sensor sample offered in the same cycle.
    assign sens_ready = ena && (state_reg == S_IDLE) && !frame_start;

    // High in exactly the cycles whose clock edge puts a pixel on the bus.
    assign pix_ready = ena && (((state_reg == S_VSYNC) && (phase_reg == VS_LAST)) ||
                               ((state_reg == S_LINE)  && (col_reg != COL_LAST)) ||
                               ((state_reg == S_GAP)   && (phase_reg == GAP_LAST)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg           <= S_IDLE;
            col_reg             <= '0;
            row_reg             <= '0;
            phase_reg           <= '0;
            pending_reg         <= 1'b0;
            bus_data_reg        <= 8'h00;
            bus_mode_camera_reg <= 1'b0;
            bus_vsync_reg       <= 1'b0;
            bus_href_reg        <= 1'b0;
            bus_sel_reg         <= 2'd0;
            bus_ena_reg         <= 1'b0;
            busy_reg            <= 1'b0;
            frame_done_reg      <= 1'b0;
            underrun_reg        <= 1'b0;
        end else if (ena) begin
            // Defaults describe a camera-mode blanking cycle; branches refine them.
            frame_done_reg      <= 1'b0;
            bus_vsync_reg       <= 1'b0;
            bus_href_reg        <= 1'b0;
            bus_data_reg        <= 8'h00;
            bus_mode_camera_reg <= 1'b1;
            bus_ena_reg         <= 1'b1;
            busy_reg            <= 1'b1;
            if (frame_req) begin
                pending_reg <= 1'b1;
            end
            if (pix_ready) begin
                bus_href_reg <= 1'b1;
                bus_data_reg <= pix_byte;
                if (!pix_valid) begin
                    underrun_reg <= 1'b1;
                end
            end
            case (state_reg)
                S_IDLE: begin
                    if (frame_start) begin
                        state_reg     <= S_VSYNC;
                        phase_reg     <= '0;
                        pending_reg   <= 1'b0;
                        bus_vsync_reg <= 1'b1;
                    end else begin
                        busy_reg            <= 1'b0;
                        bus_mode_camera_reg <= 1'b0;
                        bus_ena_reg         <= sens_valid;
                        if (sens_valid) begin
                            bus_data_reg <= sens_data;
                            bus_sel_reg  <= sens_id;
                        end
                    end
                end
                S_VSYNC: begin
                    if (phase_reg == VS_LAST) begin
                        state_reg <= S_LINE;
                        row_reg   <= '0;
                        col_reg   <= '0;
                    end else begin
                        phase_reg     <= phase_reg + PH_W'(1);
                        bus_vsync_reg <= 1'b1;
                    end
                end
                S_LINE: begin
                    if (col_reg != COL_LAST) begin
                        col_reg <= col_reg + COL_W'(1);
                    end else if (row_reg != ROW_LAST) begin
                        state_reg <= S_GAP;
                        phase_reg <= '0;
                    end else begin
                        state_reg <= S_TAIL;
                        phase_reg <= '0;
                    end
                end
                S_GAP: begin
                    if (phase_reg == GAP_LAST) begin
                        state_reg <= S_LINE;
                        row_reg   <= row_reg + ROW_W'(1);
                        col_reg   <= '0;
                    end else begin
                        phase_reg <= phase_reg + PH_W'(1);
                    end
                end
                S_TAIL: begin
                    if (phase_reg == TAIL_LAST) begin
                        state_reg           <= S_IDLE;
                        frame_done_reg      <= 1'b1;
                        busy_reg            <= 1'b0;
                        bus_mode_camera_reg <= 1'b0;
                        bus_ena_reg         <= 1'b0;
                    end else begin
                        phase_reg <= phase_reg + PH_W'(1);
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign bus_data        = bus_data_reg;
    assign bus_mode_camera = bus_mode_camera_reg;
    assign bus_vsync       = bus_vsync_reg;
    assign bus_href        = bus_href_reg;
    assign bus_sel         = bus_sel_reg;
    assign bus_ena         = bus_ena_reg;
    assign busy            = busy_reg;
    assign frame_done      = frame_done_reg;
    assign underrun        = underrun_reg;

endmodule
